// File: rtl/morse_sequencer.sv
// morse_sequencer: expands 6-bit character codes into ITU Morse key timing on key_out.
// One Morse unit lasts MAX_COUNT+1 clocks; key_out and busy are registered.
module morse_sequencer #(
  parameter int unsigned MAX_COUNT = 898
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       unit_tick
);

  localparam int unsigned CntW = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_COUNT);
  localparam logic [5:0] WordSpace = 6'd63;

  typedef enum logic [2:0] {
    StIdle,
    StMark,
    StElemGap,
    StCharGap,
    StWordGap
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] count_q;
  logic [2:0]      remaining_q;
  logic [4:0]      pattern_q;     // elements still to send, next one in bit 4
  logic [2:0]      elems_left_q;

  logic [4:0]      tbl_bits;
  logic [2:0]      tbl_len;
  logic [4:0]      tbl_aligned;
  logic            last_unit;

  // Patterns are right-aligned, dot=0 / dash=1; a zero length marks an unplayable code.
  always_comb begin
    tbl_len  = 3'd0;
    tbl_bits = 5'b00000;
    case (char_in)
      6'd0:  {tbl_len, tbl_bits} = {3'd2, 5'b00001};  // A .-
      6'd1:  {tbl_len, tbl_bits} = {3'd4, 5'b01000};  // B -...
      6'd2:  {tbl_len, tbl_bits} = {3'd4, 5'b01010};  // C -.-.
      6'd3:  {tbl_len, tbl_bits} = {3'd3, 5'b00100};  // D -..
      6'd4:  {tbl_len, tbl_bits} = {3'd1, 5'b00000};  // E .
      6'd5:  {tbl_len, tbl_bits} = {3'd4, 5'b00010};  // F ..-.
      6'd6:  {tbl_len, tbl_bits} = {3'd3, 5'b00110};  // G --.
      6'd7:  {tbl_len, tbl_bits} = {3'd4, 5'b00000};  // H ....
      6'd8:  {tbl_len, tbl_bits} = {3'd2, 5'b00000};  // I ..
      6'd9:  {tbl_len, tbl_bits} = {3'd4, 5'b00111};  // J .---
      6'd10: {tbl_len, tbl_bits} = {3'd3, 5'b00101};  // K -.-
      6'd11: {tbl_len, tbl_bits} = {3'd4, 5'b00100};  // L .-..
      6'd12: {tbl_len, tbl_bits} = {3'd2, 5'b00011};  // M --
      6'd13: {tbl_len, tbl_bits} = {3'd2, 5'b00010};  // N -.
      6'd14: {tbl_len, tbl_bits} = {3'd3, 5'b00111};  // O ---
      6'd15: {tbl_len, tbl_bits} = {3'd4, 5'b00110};  // P .--.
      6'd16: {tbl_len, tbl_bits} = {3'd4, 5'b01101};  // Q --.-
      6'd17: {tbl_len, tbl_bits} = {3'd3, 5'b00010};  // R .-.
      6'd18: {tbl_len, tbl_bits} = {3'd3, 5'b00000};  // S ...
      6'd19: {tbl_len, tbl_bits} = {3'd1, 5'b00001};  // T -
      6'd20: {tbl_len, tbl_bits} = {3'd3, 5'b00001};  // U ..-
      6'd21: {tbl_len, tbl_bits} = {3'd4, 5'b00001};  // V ...-
      6'd22: {tbl_len, tbl_bits} = {3'd3, 5'b00011};  // W .--
      6'd23: {tbl_len, tbl_bits} = {3'd4, 5'b01001};  // X -..-
      6'd24: {tbl_len, tbl_bits} = {3'd4, 5'b01011};  // Y -.--
      6'd25: {tbl_len, tbl_bits} = {3'd4, 5'b01100};  // Z --..
      6'd26: {tbl_len, tbl_bits} = {3'd5, 5'b11111};  // 0 -----
      6'd27: {tbl_len, tbl_bits} = {3'd5, 5'b01111};  // 1 .----
      6'd28: {tbl_len, tbl_bits} = {3'd5, 5'b00111};  // 2 ..---
      6'd29: {tbl_len, tbl_bits} = {3'd5, 5'b00011};  // 3 ...--
      6'd30: {tbl_len, tbl_bits} = {3'd5, 5'b00001};  // 4 ....-
      6'd31: {tbl_len, tbl_bits} = {3'd5, 5'b00000};  // 5 .....
      6'd32: {tbl_len, tbl_bits} = {3'd5, 5'b10000};  // 6 -....
      6'd33: {tbl_len, tbl_bits} = {3'd5, 5'b11000};  // 7 --...
      6'd34: {tbl_len, tbl_bits} = {3'd5, 5'b11100};  // 8 ---..
      6'd35: {tbl_len, tbl_bits} = {3'd5, 5'b11110};  // 9 ----.
      default: begin
        tbl_len  = 3'd0;
        tbl_bits = 5'b00000;
      end
    endcase
  end

  // Left-align so the first element sits in bit 4.
  assign tbl_aligned = tbl_bits << (3'd5 - tbl_len);

  assign char_ready = (state_q == StIdle);
  assign unit_tick  = (state_q != StIdle) && (count_q == CntMax);
  assign last_unit  = unit_tick && (remaining_q == 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      remaining_q  <= 3'd0;
      pattern_q    <= 5'b00000;
      elems_left_q <= 3'd0;
      key_out      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (state_q == StIdle || unit_tick) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end

      if (unit_tick) begin
        remaining_q <= remaining_q - 3'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (char_valid) begin
            if (char_in == WordSpace) begin
              state_q     <= StWordGap;
              remaining_q <= 3'd4;
              busy        <= 1'b1;
            end else if (tbl_len != 3'd0) begin
              state_q      <= StMark;
              remaining_q  <= tbl_aligned[4] ? 3'd3 : 3'd1;
              pattern_q    <= {tbl_aligned[3:0], 1'b0};
              elems_left_q <= tbl_len - 3'd1;
              key_out      <= 1'b1;
              busy         <= 1'b1;
            end
          end
        end
        StMark: begin
          if (last_unit) begin
            key_out <= 1'b0;
            if (elems_left_q != 3'd0) begin
              state_q     <= StElemGap;
              remaining_q <= 3'd1;
            end else begin
              state_q     <= StCharGap;
              remaining_q <= 3'd3;
            end
          end
        end
        StElemGap: begin
          if (last_unit) begin
            state_q      <= StMark;
            remaining_q  <= pattern_q[4] ? 3'd3 : 3'd1;
            pattern_q    <= {pattern_q[3:0], 1'b0};
            elems_left_q <= elems_left_q - 3'd1;
            key_out      <= 1'b1;
          end
        end
        StCharGap, StWordGap: begin
          if (last_unit) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          key_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: directed and randomized characters checked cycle by cycle against
// a model that builds the expected key waveform from Morse strings.
module tb_morse_sequencer;

  localparam int unsigned MC = 3;
  localparam int U = MC + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] char_in = 6'd0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       key_out;
  logic       busy;
  logic       unit_tick;

  int total = 0;
  int bad = 0;
  bit exp_key[$];

  morse_sequencer #(.MAX_COUNT(MC)) dut (
    .clk       (clk),
    .rst       (rst),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .key_out   (key_out),
    .busy      (busy),
    .unit_tick (unit_tick)
  );

  always #5 clk = ~clk;

  // Observed vector is {char_ready, key_out, busy, unit_tick}.
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic string morse_of(input int code);
    case (code)
      0: return ".-";      1: return "-...";    2: return "-.-.";    3: return "-..";
      4: return ".";       5: return "..-.";    6: return "--.";     7: return "....";
      8: return "..";      9: return ".---";    10: return "-.-";    11: return ".-..";
      12: return "--";     13: return "-.";     14: return "---";    15: return ".--.";
      16: return "--.-";   17: return ".-.";    18: return "...";    19: return "-";
      20: return "..-";    21: return "...-";   22: return ".--";    23: return "-..-";
      24: return "-.--";   25: return "--..";   26: return "-----";  27: return ".----";
      28: return "..---";  29: return "...--";  30: return "....-";  31: return ".....";
      32: return "-....";  33: return "--...";  34: return "---..";  35: return "----.";
      default: return "";
    endcase
  endfunction

  // Expected key level for every clock after acceptance until IDLE is re-entered.
  task automatic build_trace(input int code);
    string s;
    int    n;
    exp_key.delete();
    if (code == 63) begin
      repeat (4 * U) exp_key.push_back(1'b0);
    end else if (code < 36) begin
      s = morse_of(code);
      for (int i = 0; i < s.len(); i++) begin
        n = (s.getc(i) == "-") ? 3 : 1;
        if (i > 0) repeat (U) exp_key.push_back(1'b0);
        repeat (n * U) exp_key.push_back(1'b1);
      end
      repeat (3 * U) exp_key.push_back(1'b0);
    end
  endtask

  // Entered and left at a falling edge with the sequencer idle (unless limit cuts it short).
  task automatic play(input int code, input int limit);
    int  n;
    bit  tick;
    char_in    = 6'(code);
    char_valid = 1'b1;
    check($sformatf("ready_c%0d", code), {char_ready, key_out, busy, unit_tick}, 4'b1000);
    build_trace(code);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in    = 6'($urandom);
    n = (limit >= 0 && limit < exp_key.size()) ? limit : exp_key.size();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      tick = ((i % U) == 0);
      check($sformatf("c%0d_cyc%0d", code, i), {char_ready, key_out, busy, unit_tick},
            {1'b0, exp_key[i-1], 1'b1, tick});
      char_valid = 1'($urandom);
      char_in    = 6'($urandom);
    end
    if (n == exp_key.size()) begin
      @(negedge clk);
      check($sformatf("idle_after_c%0d", code), {char_ready, key_out, busy, unit_tick},
            4'b1000);
    end
    char_valid = 1'b0;
  endtask

  initial begin
    int r;
    int code;
    #7;
    check("reset", {char_ready, key_out, busy, unit_tick}, 4'b1000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    play(4, -1);    // E
    play(0, -1);    // A
    play(26, -1);   // 0, then E on the first idle cycle
    play(4, -1);
    play(4, -1);    // E followed by word space
    play(63, -1);
    play(40, -1);   // invalid, dropped
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("invalid_idle%0d", i), {char_ready, key_out, busy, unit_tick}, 4'b1000);
    end

    // Abort in the middle of the first dash of O.
    play(14, 6);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", {char_ready, key_out, busy, unit_tick}, 4'b1000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    play(4, -1);

    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       code = $urandom_range(0, 35);
      else if (r == 7) code = 63;
      else             code = $urandom_range(36, 62);
      play(code, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
